// File: rtl/stream_mux_nto1.sv
// N-channel valid/ready stream multiplexer with a one-entry registered output
// stage, external-select or round-robin arbitration, and a saturating beat counter.

module stream_mux_nto1_lane #(
  parameter int WIDTH = 8,
  parameter int SELW  = 2,
  parameter int IDX   = 0
) (
  input  logic             i_load_en,
  input  logic             i_any,
  input  logic [SELW-1:0]  i_chosen,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_grant,
  output logic [WIDTH-1:0] o_data
);
  localparam logic [SELW-1:0] MY_IDX = SELW'(IDX);

  assign o_grant = i_load_en && i_any && (i_chosen == MY_IDX);
  // AND-OR mux leg: only the granted lane contributes to the OR tree.
  assign o_data  = o_grant ? i_data : '0;
endmodule

module stream_mux_nto1 #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_ch,
  output logic [15:0]           xfer_cnt
);
  localparam logic [SELW:0] NCH_W = (SELW+1)'(N_CH);

  logic                        r_valid;
  logic [WIDTH-1:0]            r_data;
  logic [SELW-1:0]             r_ch;
  logic [15:0]                 r_cnt;

  logic                        w_load_en;
  logic                        w_any;
  logic [SELW-1:0]             w_chosen;
  logic [N_CH-1:0]             w_grant;
  logic [N_CH-1:0][WIDTH-1:0]  w_lane_data;
  logic [WIDTH-1:0]            w_mux_data;
  logic                        w_xfer;

  assign w_load_en = !r_valid || out_ready;

  generate
    if (MODE == 0) begin : g_sel
      assign w_chosen = sel;
      assign w_any    = ({1'b0, sel} < NCH_W);
    end else begin : g_rr
      logic [SELW-1:0]   r_last;
      logic [SELW:0]     w_base;
      logic [2*N_CH-1:0] w_dbl;
      logic [N_CH-1:0]   w_rot;
      logic              w_rr_any;
      logic [SELW:0]     w_rr_off;
      logic [SELW:0]     w_sum;
      logic              w_unused_sel;

      assign w_unused_sel = ^sel;

      // Rotate valids so bit 0 is the channel just after the last grant.
      assign w_base = {1'b0, r_last} + (SELW+1)'(1);
      assign w_dbl  = {in_valid, in_valid};
      assign w_rot  = N_CH'(w_dbl >> w_base);

      always_comb begin
        w_rr_any = 1'b0;
        w_rr_off = '0;
        for (int k = N_CH-1; k >= 0; k--) begin
          if (w_rot[k]) begin
            w_rr_any = 1'b1;
            w_rr_off = (SELW+1)'(k);
          end
        end
        w_sum = w_base + w_rr_off;
        if (w_sum >= NCH_W) w_sum = w_sum - NCH_W;
      end

      assign w_chosen = w_sum[SELW-1:0];
      assign w_any    = w_rr_any;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_last <= SELW'(N_CH-1);
        else if (w_xfer) r_last <= w_chosen;
      end
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
      stream_mux_nto1_lane #(
        .WIDTH (WIDTH),
        .SELW  (SELW),
        .IDX   (i)
      ) u_lane (
        .i_load_en (w_load_en),
        .i_any     (w_any),
        .i_chosen  (w_chosen),
        .i_data    (in_data[i*WIDTH +: WIDTH]),
        .o_grant   (w_grant[i]),
        .o_data    (w_lane_data[i])
      );
    end
  endgenerate

  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < N_CH; i++) w_mux_data = w_mux_data | w_lane_data[i];
  end

  assign w_xfer   = |(w_grant & in_valid);
  assign in_ready = rst ? '0 : w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_mux_data;
      r_ch    <= w_chosen;
      if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: three configurations (select N=4, round-robin N=4,
// select N=3) checked every cycle against a queue-free behavioural model.

module tb_stream_mux_nto1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // instance A: N=4, MODE=0
  logic [31:0] a_data;  logic [3:0] a_vld, a_rdy;  logic [1:0] a_sel, a_och;
  logic [7:0]  a_od;    logic a_ov, a_ordy;        logic [15:0] a_cnt;
  // instance B: N=4, MODE=1
  logic [31:0] b_data;  logic [3:0] b_vld, b_rdy;  logic [1:0] b_sel, b_och;
  logic [7:0]  b_od;    logic b_ov, b_ordy;        logic [15:0] b_cnt;
  // instance C: N=3, MODE=0
  logic [23:0] c_data;  logic [2:0] c_vld, c_rdy;  logic [1:0] c_sel, c_och;
  logic [7:0]  c_od;    logic c_ov, c_ordy;        logic [15:0] c_cnt;

  stream_mux_nto1 #(.N_CH(4), .WIDTH(8), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_vld), .in_ready(a_rdy),
    .sel(a_sel), .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy),
    .out_ch(a_och), .xfer_cnt(a_cnt));
  stream_mux_nto1 #(.N_CH(4), .WIDTH(8), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_vld), .in_ready(b_rdy),
    .sel(b_sel), .out_data(b_od), .out_valid(b_ov), .out_ready(b_ordy),
    .out_ch(b_och), .xfer_cnt(b_cnt));
  stream_mux_nto1 #(.N_CH(3), .WIDTH(8), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_vld), .in_ready(c_rdy),
    .sel(c_sel), .out_data(c_od), .out_valid(c_ov), .out_ready(c_ordy),
    .out_ch(c_och), .xfer_cnt(c_cnt));

  typedef struct { bit v; int d; int ch; int cnt; int last; } mst_t;
  mst_t ma, mb, mc;

  function automatic mst_t m_reset(input int n);
    mst_t r;
    r.v = 0; r.d = 0; r.ch = 0; r.cnt = 0; r.last = n - 1;
    return r;
  endfunction

  // Channel the rules pick this cycle, -1 when none.
  function automatic int m_pick(input mst_t s, input int n, input int mode,
                                input int sel, input logic [15:0] vld);
    if (mode == 0) return (sel < n) ? sel : -1;
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (s.last + k) % n;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_ready(input mst_t s, input int n, input int mode,
      input int sel, input logic [15:0] vld, input logic ordy, input logic r);
    int c;
    if (r || (s.v && !ordy)) return 16'h0;
    c = m_pick(s, n, mode, sel, vld);
    if (c < 0) return 16'h0;
    return 16'h1 << c;
  endfunction

  function automatic mst_t m_next(input mst_t s, input int n, input int mode, input int sel,
      input logic [15:0] vld, input logic [127:0] dat, input logic ordy);
    mst_t r;
    int c;
    r = s;
    c = m_pick(s, n, mode, sel, vld);
    if ((!s.v || ordy) && c >= 0 && vld[c]) begin
      r.v = 1; r.d = int'(dat[c*8 +: 8]); r.ch = c;
      if (r.cnt < 65535) r.cnt = r.cnt + 1;
      if (mode == 1) r.last = c;
    end else if (s.v && ordy) begin
      r.v = 0;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= m_reset(4); mb <= m_reset(4); mc <= m_reset(3);
    end else begin
      ma <= m_next(ma, 4, 0, int'(a_sel), 16'(a_vld), 128'(a_data), a_ordy);
      mb <= m_next(mb, 4, 1, int'(b_sel), 16'(b_vld), 128'(b_data), b_ordy);
      mc <= m_next(mc, 3, 0, int'(c_sel), 16'(c_vld), 128'(c_data), c_ordy);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("a_ready", 32'(a_rdy), 32'(m_ready(ma, 4, 0, int'(a_sel), 16'(a_vld), a_ordy, rst)));
    chk("a_valid", 32'(a_ov), 32'(ma.v));
    chk("a_data",  32'(a_od), 32'(ma.d));
    chk("a_ch",    32'(a_och), 32'(ma.ch));
    chk("a_cnt",   32'(a_cnt), 32'(ma.cnt));
    chk("b_ready", 32'(b_rdy), 32'(m_ready(mb, 4, 1, int'(b_sel), 16'(b_vld), b_ordy, rst)));
    chk("b_valid", 32'(b_ov), 32'(mb.v));
    chk("b_data",  32'(b_od), 32'(mb.d));
    chk("b_ch",    32'(b_och), 32'(mb.ch));
    chk("b_cnt",   32'(b_cnt), 32'(mb.cnt));
    chk("c_ready", 32'(c_rdy), 32'(m_ready(mc, 3, 0, int'(c_sel), 16'(c_vld), c_ordy, rst)));
    chk("c_valid", 32'(c_ov), 32'(mc.v));
    chk("c_data",  32'(c_od), 32'(mc.d));
    chk("c_ch",    32'(c_och), 32'(mc.ch));
    chk("c_cnt",   32'(c_cnt), 32'(mc.cnt));
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] pt_exp [4];
    pt_exp = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    rst = 1'b1;
    a_data = 32'hD3C2B1A0; b_data = 32'h44332211; c_data = 24'h998877;
    a_vld = 4'hF; b_vld = 4'hF; c_vld = 3'h7;
    a_sel = 2'd2; b_sel = 2'd0; c_sel = 2'd0;
    a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_ready", 32'(a_rdy), 32'h0);
    chk("rst_b_ready", 32'(b_rdy), 32'h0);
    chk("rst_a_valid", 32'(a_ov), 32'h0);
    chk("rst_a_data",  32'(a_od), 32'h0);
    chk("rst_a_cnt",   32'(a_cnt), 32'h0);
    #1;
    rst = 1'b0;
    a_vld = 4'h0; b_vld = 4'h0; c_vld = 3'h0;
    @(negedge clk);
    chk("rel_a_ready", 32'(a_rdy), 32'h4);

    // select pass-through, one channel per cycle
    a_vld = 4'hF;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      @(posedge clk); #2;
      chk("pt_data", 32'(a_od), 32'(pt_exp[s]));
      chk("pt_ch",   32'(a_och), 32'(s));
    end
    chk("pt_cnt", 32'(a_cnt), 32'd4);
    a_vld = 4'h0;

    // back-pressure after one beat
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    a_sel = 2'd0; a_vld = 4'hF; a_ordy = 1'b1;
    tick();
    a_ordy = 1'b0; a_sel = 2'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      chk("bp_hold_data", 32'(a_od), 32'hA0);
      chk("bp_hold_rdy",  32'(a_rdy), 32'h0);
      chk("bp_hold_vld",  32'(a_ov), 32'h1);
    end
    a_ordy = 1'b1;
    @(posedge clk); #2;
    chk("bp_next_data", 32'(a_od), 32'hB1);
    chk("bp_next_cnt",  32'(a_cnt), 32'd2);
    a_vld = 4'h0;

    // round-robin, all valid then a sparse set
    b_vld = 4'hF; b_ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      chk("rr_full_ch", 32'(b_och), 32'(k % 4));
    end
    b_vld = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      chk("rr_sparse_ch", 32'(b_och), (k % 2 == 0) ? 32'd1 : 32'd3);
    end
    b_vld = 4'h0;

    // out-of-range select on the 3-channel instance
    c_sel = 2'd3; c_vld = 3'h7; c_ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("oor_ready", 32'(c_rdy), 32'h0);
      chk("oor_valid", 32'(c_ov), 32'h0);
      chk("oor_cnt",   32'(c_cnt), 32'h0);
    end

    // randomized traffic on all instances
    for (int k = 0; k < 3000; k++) begin
      tick();
      a_data = $urandom; b_data = $urandom; c_data = 24'($urandom);
      a_vld = 4'($urandom); b_vld = 4'($urandom); c_vld = 3'($urandom);
      a_sel = 2'($urandom); c_sel = 2'($urandom);
      a_ordy = ($urandom_range(3) != 0);
      b_ordy = ($urandom_range(3) != 0);
      c_ordy = ($urandom_range(3) != 0);
    end

    // saturate the round-robin counter
    b_vld = 4'hF; b_ordy = 1'b1;
    repeat (65540) tick();
    #1;
    chk("sat_cnt",   32'(b_cnt), 32'hFFFF);
    chk("sat_valid", 32'(b_ov), 32'h1);

    // async reset between edges
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(b_ov), 32'h0);
    chk("arst_cnt",   32'(b_cnt), 32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_mux_nto1.md
Name: stream_mux_nto1

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the plain combinational 4:1 mux. Adds a registered output stage, back-pressure, a round-robin arbitration mode and a saturating transfer counter.
- Sits between multiple producer streams and a single consumer in the datapath.

Parameters:
- N_CH, 4, number of input channels (2..16; need not be a power of two).
- WIDTH, 8, data width per channel in bits.
- MODE, 0, arbitration mode: 0 = external select via sel, 1 = round-robin among valid channels.
- SELW, $clog2(N_CH), width of sel and out_ch (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready; combinational.
- sel  in  SELW  channel select; used only when MODE=0.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.
- out_ch  out  SELW  index of the channel that supplied out_data; registered.
- xfer_cnt  out  16  count of accepted input beats; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync use after deassert):
  - out_data=0, out_valid=0, out_ch=0, xfer_cnt=0.
  - Round-robin pointer last_grant = N_CH-1, so the first grant searches from ch0.
  - in_ready is forced to all-zero while rst=1.
- Output stage holds one entry. load_en = !out_valid || out_ready.
- Choice of channel (combinational):
  - MODE=0: chosen = sel. If sel >= N_CH, no channel is chosen and in_ready is all-zero.
  - MODE=1: chosen = first i with in_valid[i]=1, scanning (last_grant+1) mod N_CH upward with wrap-around. If no channel is valid, none is chosen.
- in_ready[i] = load_en && (i == chosen). Ready does not depend on in_valid[i] in MODE=0; in MODE=1 only a valid channel is ever chosen.
- Transfer: on a clock edge where in_valid[chosen] && in_ready[chosen]:
  - out_data <= in_data of chosen; out_ch <= chosen; out_valid <= 1.
  - MODE=1 only: last_grant <= chosen.
  - xfer_cnt <= xfer_cnt+1, unless it is already 16'hFFFF (holds).
- Drain: out_valid && out_ready with no new transfer on the same edge -> out_valid <= 0. out_data and out_ch keep their last values.
- Simultaneous drain and load: the new beat replaces the old in the same cycle, out_valid stays 1. Sustained throughput is one beat per cycle.
- Stall: while out_valid && !out_ready, out_data and out_ch are stable and in_ready is all-zero. No beat is lost or duplicated.
- Latency: one cycle from input handshake to out_valid.
- sel changes mid-stall (MODE=0): there is no effect on the held output; the new sel applies when load_en next rises.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N_CH-1,0,...
- An idle channel is skipped without costing a cycle.
- Reset asserted mid-stream: the output entry is discarded immediately (out_valid=0 asynchronously) and the counter clears.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, xfer_cnt=0. After release in MODE=0, sel=2 -> in_ready=4'b0100.
- MODE=0 pass-through: N_CH=4, WIDTH=8, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, all valid, out_ready=1, sel swept 0..3 one per cycle -> out_data is A0,B1,C2,D3 one cycle later each, out_ch=0..3, xfer_cnt=4.
- Back-pressure: out_ready=0 after the first beat (A0), sel=1 held for 5 cycles -> out_data stays A0, in_ready=0. out_ready=1 -> out_data=B1 next cycle, xfer_cnt=2.
- Round-robin: MODE=1, all valid, out_ready=1, 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 -> grants alternate 1,3,1,3.
- Out-of-range select: N_CH=3, SELW=2, sel=3 with all valid -> in_ready=3'b000, out_valid stays 0, xfer_cnt unchanged.
- Counter saturation and async reset: force 65537 transfers -> xfer_cnt=16'hFFFF held. Then assert rst mid-cycle while out_valid=1 -> out_valid drops to 0 before the next edge and xfer_cnt=0.
